// File: rtl/helio_pkg.sv
// Shared encodings and the manual-level duty table for the HelioSmart PWM dimmer.
package helio_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_MAN  = 2'b01;
  localparam logic [1:0] MODE_AUTO = 2'b10;

  typedef enum logic [1:0] {
    OCC_VACANT   = 2'd0,
    OCC_OCCUPIED = 2'd1,
    OCC_HOLD     = 2'd2
  } occ_state_e;

  // 3-bit manual level -> duty in clk cycles of one PWM period
  function automatic logic [15:0] lvl_to_duty(input logic [2:0] lvl, input int unsigned period);
    int unsigned d;
    case (lvl)
      3'd0:    d = 0;
      3'd1:    d = period / 16;
      3'd2:    d = period / 8;
      3'd3:    d = period / 4;
      3'd4:    d = (3 * period) / 8;
      3'd5:    d = period / 2;
      3'd6:    d = (3 * period) / 4;
      default: d = period;
    endcase
    return 16'(d);
  endfunction

endpackage

// File: rtl/pwm_dimmer_multi_if.sv
// Control/sensor inputs and LED outputs of the dimmer, grouped for the top port.
interface pwm_dimmer_multi_if #(parameter int N_CH = 4);
  logic [1:0]        mode;
  logic [3*N_CH-1:0] level;
  logic [15:0]       sensor;
  logic [9:0]        presence;
  logic [N_CH-1:0]   ch_en;
  logic [N_CH-1:0]   pwm;
  logic              occupied;
  logic [N_CH-1:0]   busy;

  modport master (output mode, level, sensor, presence, ch_en,
                  input  pwm, occupied, busy);
  modport slave  (input  mode, level, sensor, presence, ch_en,
                  output pwm, occupied, busy);
endinterface

// File: rtl/pwm_fade_channel.sv
// One PWM channel: duty register that slews toward its target only at period boundaries.
module pwm_fade_channel #(
  parameter int PERIOD    = 10000,
  parameter int FADE_STEP = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] tgt,
  input  logic        boundary,
  input  logic [15:0] cnt,
  output logic        pwm,
  output logic        busy
);
  localparam logic [15:0] STEP = 16'(FADE_STEP);

  logic [15:0] duty_q, duty_d;
  logic        pwm_q, pwm_d;
  logic        busy_q, busy_d;

  always_comb begin
    duty_d = duty_q;
    if (boundary) begin
      if (tgt > duty_q)
        duty_d = (tgt - duty_q <= STEP) ? tgt : duty_q + STEP;
      else if (tgt < duty_q)
        duty_d = (duty_q - tgt <= STEP) ? tgt : duty_q - STEP;
    end
    pwm_d  = (cnt < duty_q);
    busy_d = (duty_d != tgt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      busy_q <= busy_d;
    end
  end

  assign pwm  = pwm_q;
  assign busy = busy_q;

endmodule

// File: rtl/pwm_dimmer_multi.sv
// Multi-channel LED dimmer: shared period counter, occupancy/hold FSM, per-channel target mux.
module pwm_dimmer_multi
  import helio_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int PERIOD    = 10000,
  parameter int FADE_STEP = 100,
  parameter int PRES_THR  = 100,
  parameter int HOLD_PER  = 500
) (
  input logic              clk,
  input logic              rst_n,
  pwm_dimmer_multi_if.slave bus
);
  localparam logic [15:0] CNT_MAX = 16'(PERIOD - 1);
  localparam logic [15:0] PER16   = 16'(PERIOD);
  localparam int          HW      = $clog2(HOLD_PER + 1);

  logic [15:0] cnt_q, cnt_d;
  logic        boundary;

  occ_state_e  state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic        occ_q, occ_d;
  logic        pres;

  logic [15:0] auto_tgt;
  logic [N_CH-1:0][15:0] tgt;

  assign boundary = (cnt_q == CNT_MAX);
  assign pres     = (bus.presence < 10'(PRES_THR));

  always_comb begin
    cnt_d = boundary ? '0 : cnt_q + 16'd1;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= OCC_VACANT;
      hold_q  <= '0;
      occ_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      occ_q   <= occ_d;
    end
  end

  // next state; returning presence beats an expiring timer
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      OCC_VACANT: begin
        if (pres) state_d = OCC_OCCUPIED;
      end
      OCC_OCCUPIED: begin
        if (!pres) begin
          state_d = OCC_HOLD;
          hold_d  = HW'(HOLD_PER);
        end
      end
      OCC_HOLD: begin
        if (pres) begin
          state_d = OCC_OCCUPIED;
          hold_d  = '0;
        end else if (boundary) begin
          if (hold_q == '0) state_d = OCC_VACANT;
          else              hold_d  = hold_q - HW'(1);
        end
      end
      default: begin
        state_d = OCC_VACANT;
        hold_d  = '0;
      end
    endcase
  end

  // outputs
  always_comb begin
    occ_d = (state_d != OCC_VACANT);
  end

  // sensor >= PERIOD is checked at 17 bits so the subtraction below never wraps
  always_comb begin
    auto_tgt = '0;
    if ({1'b0, bus.sensor} < {1'b0, PER16})
      auto_tgt = PER16 - bus.sensor;
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      tgt[i] = '0;
      if (bus.ch_en[i] && occ_q) begin
        if (bus.mode == MODE_MAN)
          tgt[i] = lvl_to_duty(bus.level[3*i +: 3], PERIOD);
        else if (bus.mode == MODE_AUTO)
          tgt[i] = auto_tgt;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_fade_channel #(
      .PERIOD    (PERIOD),
      .FADE_STEP (FADE_STEP)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tgt      (tgt[i]),
      .boundary (boundary),
      .cnt      (cnt_q),
      .pwm      (bus.pwm[i]),
      .busy     (bus.busy[i])
    );
  end

  assign bus.occupied = occ_q;

endmodule

// File: tb/tb_pwm_dimmer_multi.sv
// Directed bench for pwm_dimmer_multi at PERIOD=100, FADE_STEP=10, HOLD_PER=3, N_CH=2.
module tb_pwm_dimmer_multi;
  import helio_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_dimmer_multi_if #(.N_CH(2)) bus();

  pwm_dimmer_multi #(
    .N_CH(2), .PERIOD(100), .FADE_STEP(10), .PRES_THR(100), .HOLD_PER(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] d0, d1;
  assign d0 = dut.g_ch[0].u_ch.duty_q;
  assign d1 = dut.g_ch[1].u_ch.duty_q;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  // stop at the negedge where the counter sits at PERIOD-1
  task automatic wait99();
    int n = 0;
    @(negedge clk);
    while (dut.cnt_q != 16'd99 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("bnd_timeout", 0, 1);
  endtask

  task automatic next_bnd();
    wait99();
    @(negedge clk);
  endtask

  // called at the negedge with cnt=0; counts high cycles of one full period
  task automatic measure(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    repeat (100) begin
      @(negedge clk);
      h0 += int'(bus.pwm[0]);
      h1 += int'(bus.pwm[1]);
    end
  endtask

  int h0, h1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mode     = MODE_MAN;
    bus.level    = {3'd3, 3'd7};
    bus.sensor   = 16'd0;
    bus.presence = 10'd50;
    bus.ch_en    = 2'b11;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(bus.pwm), 0);
    chk("rst_occ", int'(bus.occupied), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_duty", int'(d0), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("occ_on", int'(bus.occupied), 1);

    // manual ramp to full
    for (int k = 1; k <= 10; k++) begin
      next_bnd();
      chk($sformatf("ramp0_%0d", k), int'(d0), 10 * k);
      chk($sformatf("ramp1_%0d", k), int'(d1), (10 * k > 25) ? 25 : 10 * k);
      if (k == 1) chk("busy0_ramp", int'(bus.busy[0]), 1);
    end
    chk("busy0_done", int'(bus.busy[0]), 0);
    chk("busy1_done", int'(bus.busy[1]), 0);
    measure(h0, h1);
    chk("full_h0", h0, 100);
    chk("lvl3_h1", h1, 25);

    // auto, sensor=30, channel 1 disabled
    bus.mode   = MODE_AUTO;
    bus.sensor = 16'd30;
    bus.ch_en  = 2'b01;
    next_bnd(); chk("auto_a0", int'(d0), 90); chk("auto_a1", int'(d1), 15);
    next_bnd(); chk("auto_b0", int'(d0), 80); chk("auto_b1", int'(d1), 5);
    next_bnd(); chk("auto_c0", int'(d0), 70); chk("auto_c1", int'(d1), 0);
    measure(h0, h1);
    chk("auto_h0", h0, 70);
    chk("auto_h1", h1, 0);
    chk("auto_busy0", int'(bus.busy[0]), 0);

    // sensor beyond period: fade out, each period sees exactly one duty
    bus.sensor = 16'd120;
    for (int k = 0; k < 7; k++) begin
      measure(h0, h1);
      chk($sformatf("dn_h0_%0d", k), h0, 70 - 10 * k);
      chk($sformatf("dn_d0_%0d", k), int'(d0), 60 - 10 * k);
    end
    measure(h0, h1);
    chk("dn_zero_h0", h0, 0);

    // occupancy hold and expiry
    bus.mode  = MODE_MAN;
    bus.level = {3'd0, 3'd2};
    bus.ch_en = 2'b11;
    next_bnd(); chk("h_up_a", int'(d0), 10);
    next_bnd(); chk("h_up_b", int'(d0), 12);
    bus.presence = 10'd200;
    @(negedge clk);
    chk("hold_enter", int'(bus.occupied), 1);
    for (int k = 1; k <= 3; k++) begin
      next_bnd();
      chk($sformatf("hold_%0d", k), int'(bus.occupied), 1);
    end
    next_bnd();
    chk("hold_expire", int'(bus.occupied), 0);
    chk("hold_exp_d0", int'(d0), 12);
    next_bnd(); chk("fade_a", int'(d0), 2);
    next_bnd(); chk("fade_b", int'(d0), 0);

    // presence returns on the expiry boundary
    bus.presence = 10'd50;
    @(negedge clk);
    chk("reocc", int'(bus.occupied), 1);
    next_bnd(); chk("r_up_a", int'(d0), 10);
    next_bnd(); chk("r_up_b", int'(d0), 12);
    bus.presence = 10'd200;
    for (int k = 1; k <= 3; k++) next_bnd();
    chk("r_hold", int'(bus.occupied), 1);
    wait99();
    bus.presence = 10'd50;
    @(negedge clk);
    chk("race_occ", int'(bus.occupied), 1);
    next_bnd();
    chk("race_occ2", int'(bus.occupied), 1);
    chk("race_d0", int'(d0), 12);

    // manual redirect mid-ramp
    bus.level = {3'd0, 3'd0};
    next_bnd(); chk("m0_a", int'(d0), 2);
    next_bnd(); chk("m0_b", int'(d0), 0);
    bus.level = {3'd0, 3'd7};
    for (int k = 1; k <= 4; k++) begin
      next_bnd();
      chk($sformatf("m7_%0d", k), int'(d0), 10 * k);
    end
    bus.level = {3'd0, 3'd2};
    next_bnd(); chk("m2_a", int'(d0), 30);
    next_bnd(); chk("m2_b", int'(d0), 20);
    next_bnd(); chk("m2_c", int'(d0), 12);
    chk("m2_busy", int'(bus.busy[0]), 0);

    // async reset mid-ramp
    bus.level = {3'd0, 3'd7};
    next_bnd(); chk("rr_a", int'(d0), 22);
    next_bnd(); chk("rr_b", int'(d0), 32);
    repeat (10) @(negedge clk);
    chk("rr_pwm_hi", int'(bus.pwm[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_pwm", int'(bus.pwm), 0);
    chk("rr_occ", int'(bus.occupied), 0);
    chk("rr_busy", int'(bus.busy), 0);
    chk("rr_duty", int'(d0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rr_occ_on", int'(bus.occupied), 1);
    next_bnd();
    chk("rr_restart", int'(d0), 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
